// File: rtl/apb_ram_param_if.sv
// APB slave-side bus bundle for apb_ram_param; parity_inject exists only when APB_RAM_PARITY_EN is defined.
interface apb_ram_param_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int PADDR_WIDTH = 16
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [PADDR_WIDTH-1:0]  paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;
`ifdef APB_RAM_PARITY_EN
  logic                    parity_inject;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, parity_inject,
    input  prdata, pready, pslverr
  );
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, parity_inject,
    output prdata, pready, pslverr
  );
`else
  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
`endif
endinterface

// File: rtl/apb_ram_param.sv
// Parametrised APB RAM slave: pready in access cycle WAIT_STATES+1, byte strobes, pslverr on bad address.
// APB_RAM_PARITY_EN adds per-byte even parity with inject port; parity mismatch on read raises pslverr.
module apb_ram_param #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int PADDR_WIDTH = 16,
  parameter int WAIT_STATES = 0
) (
  input logic             i_pclk,
  input logic             i_preset,
  apb_ram_param_if.slave  s_apb
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFS = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam int CW  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [IW-1:0]         r_idx;
  logic                  r_write;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [PADDR_WIDTH-1:0] w_lo_mask;
  logic [31:0]            w_widx32;
  logic [IW-1:0]          w_idx;
  logic                   w_addr_err;
  logic                   w_setup;
  logic                   w_pready;
  logic                   w_commit;
  logic                   w_par_err;

  assign w_lo_mask  = PADDR_WIDTH'((1 << OFS) - 1);
  assign w_widx32   = 32'(s_apb.paddr) >> OFS;
  assign w_idx      = w_widx32[IW-1:0];
  assign w_addr_err = ((s_apb.paddr & w_lo_mask) != '0) || (w_widx32 >= 32'(DEPTH));
  assign w_setup    = (r_state == IDLE) && s_apb.psel && !s_apb.penable;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pready    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_setup) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = '0;
        end
      end
      ACCESS: begin
        if (s_apb.psel && s_apb.penable) begin
          if (r_cnt == CW'(WAIT_STATES)) begin
            w_pready    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A read's data is fetched at the setup edge so it is ready by the first ACCESS cycle.
  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_setup) begin
        r_idx   <= w_idx;
        r_write <= s_apb.pwrite;
        r_err   <= w_addr_err;
        if (!w_addr_err && !s_apb.pwrite) begin
          r_rdata <= r_mem[w_idx];
        end
      end
    end
  end

  assign w_commit = w_pready && r_write && !r_err && !i_preset;

`ifdef APB_RAM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] r_rpar;
  logic [NB-1:0] w_calc_par;

  always_comb begin
    w_calc_par = '0;
    for (int b = 0; b < NB; b++) begin
      w_calc_par[b] = ^r_rdata[b*8 +: 8];
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      r_rpar <= '0;
    end else if (w_setup && !w_addr_err && !s_apb.pwrite) begin
      r_rpar <= r_par[w_idx];
    end
  end

  always_ff @(posedge i_pclk) begin
    if (w_commit) begin
      for (int b = 0; b < NB; b++) begin
        if (s_apb.pstrb[b]) begin
          r_par[r_idx][b] <= (^s_apb.pwdata[b*8 +: 8]) ^ s_apb.parity_inject;
        end
      end
    end
  end

  assign w_par_err = |(r_rpar ^ w_calc_par);
`else
  assign w_par_err = 1'b0;
`endif

  always_ff @(posedge i_pclk) begin
    if (w_commit) begin
      for (int b = 0; b < NB; b++) begin
        if (s_apb.pstrb[b]) begin
          r_mem[r_idx][b*8 +: 8] <= s_apb.pwdata[b*8 +: 8];
        end
      end
    end
  end

  assign s_apb.pready  = w_pready;
  assign s_apb.pslverr = w_pready && (r_err || (!r_write && w_par_err));
  assign s_apb.prdata  = (w_pready && !r_write && !r_err) ? r_rdata : '0;

endmodule
